// File: rtl/module_stereo_adc_input_pkg.sv
// ---------------------------------------------------------------------------
// module_stereo_adc_input_pkg
//
// Shared constants and helpers for the stereo sigma-delta ADC front end.
//
// Contents:
//   CLK_DIV_1536K : clk cycles per 1536 kHz modulator tick at 49.152 MHz
//   CIC_ORDER     : number of integrator/comb stages in the decimator
//   DECIM_LOG2    : log2 of the decimation ratio (R = 32)
//   SAMPLE_W      : width of the signed output samples
//   OUT_SHIFT     : left shift taking the CIC result to full output scale
//   scaled_t      : saturated sample plus its clip flag
//   scale_sat()   : CIC result -> saturated, scaled output sample
// ---------------------------------------------------------------------------
package module_stereo_adc_input_pkg;

    localparam int CLK_DIV_1536K = 32;
    localparam int CIC_ORDER     = 3;
    localparam int DECIM_LOG2    = 5;
    localparam int SAMPLE_W      = 18;
    localparam int OUT_SHIFT     = 2;

    localparam int SAMPLE_MAX    = (1 << (SAMPLE_W - 1)) - 1;
    localparam int SAMPLE_MIN    = -(1 << (SAMPLE_W - 1));

    typedef struct packed {
        logic [SAMPLE_W-1:0] sample;
        logic                clip;
    } scaled_t;

    // The CIC gain is R^3 = 32768, so a full-scale input of all ones lands
    // exactly one LSB beyond what fits after the x4 shift. That single code
    // is folded back to the positive rail and flagged. The negative rail is
    // reachable exactly, so it is not a clip. Anything further out can only
    // appear while the modular integrators are still warming up.
    function automatic scaled_t scale_sat(input int y);
        scaled_t res;
        res.sample = '0;
        res.clip   = 1'b0;
        if (y > (SAMPLE_MAX >>> OUT_SHIFT)) begin
            res.sample = SAMPLE_W'(SAMPLE_MAX);
            res.clip   = 1'b1;
        end else if (y < (SAMPLE_MIN >>> OUT_SHIFT)) begin
            res.sample = SAMPLE_W'(SAMPLE_MIN);
            res.clip   = 1'b1;
        end else begin
            res.sample = SAMPLE_W'(y <<< OUT_SHIFT);
        end
        return res;
    endfunction

endpackage

// File: rtl/module_stereo_adc_input_cic3_decim_ch.sv
// ---------------------------------------------------------------------------
// cic3_decim_ch
//
// One channel of the sigma-delta front end: input synchroniser, feedback
// register, 3rd-order CIC decimator (D=1) and saturating output scaler.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   bit_in   in   comparator output, asynchronous to clk
//   tick     in   one-cycle strobe at the 1536 kHz modulator rate
//   comb_go  in   one-cycle strobe, cycle after the frame-end tick
//   fb       out  feedback bit back to the RC integrator
//   sample   out  signed decimated sample, loads at the end of comb_go
//   clip     out  sample was saturated, loads with sample
// ---------------------------------------------------------------------------
module cic3_decim_ch
    import module_stereo_adc_input_pkg::*;
#(
    parameter int CIC_W = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bit_in,
    input  logic                tick,
    input  logic                comb_go,
    output logic                fb,
    output logic [SAMPLE_W-1:0] sample,
    output logic                clip
);

    logic             sync_q1;
    logic             sync_q2;
    logic [CIC_W-1:0] x_step;
    logic [CIC_W-1:0] int1;
    logic [CIC_W-1:0] int2;
    logic [CIC_W-1:0] int3;
    logic [CIC_W-1:0] dly1;
    logic [CIC_W-1:0] dly2;
    logic [CIC_W-1:0] dly3;
    logic [CIC_W-1:0] comb1;
    logic [CIC_W-1:0] comb2;
    logic [CIC_W-1:0] comb3;
    scaled_t          scaled;

    // Two-flop synchroniser; the comparator output is free-running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= bit_in;
            sync_q2 <= sync_q1;
        end
    end

    // Modulator bit mapped to +1 / -1 in two's complement.
    assign x_step = sync_q2 ? CIC_W'(1) : {CIC_W{1'b1}};

    // Integrator cascade, each stage fed by the previous stage's old value.
    // Wrap-around is intentional: the combs cancel it as long as CIC_W
    // covers the full CIC gain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb   <= 1'b0;
            int1 <= '0;
            int2 <= '0;
            int3 <= '0;
        end else if (tick) begin
            fb   <= sync_q2;
            int1 <= int1 + x_step;
            int2 <= int2 + int1;
            int3 <= int3 + int2;
        end
    end

    // Comb cascade evaluated combinationally; only registered on comb_go.
    always_comb begin
        comb1  = int3  - dly1;
        comb2  = comb1 - dly2;
        comb3  = comb2 - dly3;
        scaled = scale_sat(int'($signed(comb3)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly1   <= '0;
            dly2   <= '0;
            dly3   <= '0;
            sample <= '0;
            clip   <= 1'b0;
        end else if (comb_go) begin
            dly1   <= int3;
            dly2   <= comb1;
            dly3   <= comb2;
            sample <= scaled.sample;
            clip   <= scaled.clip;
        end
    end

endmodule

// File: rtl/module_stereo_adc_input.sv
// ---------------------------------------------------------------------------
// module_stereo_adc_input
//
// Stereo sigma-delta ADC front end. Samples two 1-bit modulator streams at
// 1536 kHz, returns the feedback bits to the external loops and decimates
// each stream by 32 with a 3rd-order CIC into 18-bit signed 48 kHz samples.
//
// Ports:
//   clk             in   system clock (49.152 MHz nominal)
//   reset           in   asynchronous, active-high reset
//   adc_in_l/r      in   comparator outputs, asynchronous to clk
//   adc_fb_l/r      out  feedback bits to the RC integrators
//   sample_out_rdy  out  one-cycle pulse, samples and clip flags valid
//   sample_out_l/r  out  signed 18-bit samples, held between pulses
//   clip_l/r        out  saturation flags, valid with sample_out_rdy
// ---------------------------------------------------------------------------
module module_stereo_adc_input
    import module_stereo_adc_input_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_1536K,
    parameter int DECIM   = 32,
    parameter int CIC_W   = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                adc_in_l,
    input  logic                adc_in_r,
    output logic                adc_fb_l,
    output logic                adc_fb_r,
    output logic                sample_out_rdy,
    output logic [SAMPLE_W-1:0] sample_out_l,
    output logic [SAMPLE_W-1:0] sample_out_r,
    output logic                clip_l,
    output logic                clip_r
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // tick and comb_go must land in different cycles, and the output scaling
    // assumes a CIC gain of exactly 32^3.
    if (CLK_DIV < 3) begin : g_bad_clk_div
        $error("module_stereo_adc_input: CLK_DIV must be at least 3");
    end
    if (DECIM != (1 << DECIM_LOG2)) begin : g_bad_decim
        $error("module_stereo_adc_input: DECIM must be 32");
    end

    logic [DIV_W-1:0]      div_cnt;
    logic [DECIM_LOG2-1:0] dec_cnt;
    logic                  tick;
    logic                  frame_end;
    logic                  comb_go;

    assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign frame_end = tick && (dec_cnt == DECIM_LOG2'(DECIM - 1));

    // Modulator-rate divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Ticks per output frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_cnt <= '0;
        end else if (tick) begin
            if (dec_cnt == DECIM_LOG2'(DECIM - 1)) begin
                dec_cnt <= '0;
            end else begin
                dec_cnt <= dec_cnt + 1'b1;
            end
        end
    end

    // comb_go follows the frame-end tick by one cycle so the combs see the
    // freshly updated int3; the ready pulse follows once the samples load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comb_go        <= 1'b0;
            sample_out_rdy <= 1'b0;
        end else begin
            comb_go        <= frame_end;
            sample_out_rdy <= comb_go;
        end
    end

    cic3_decim_ch #(
        .CIC_W (CIC_W)
    ) u_ch_l (
        .clk     (clk),
        .reset   (reset),
        .bit_in  (adc_in_l),
        .tick    (tick),
        .comb_go (comb_go),
        .fb      (adc_fb_l),
        .sample  (sample_out_l),
        .clip    (clip_l)
    );

    cic3_decim_ch #(
        .CIC_W (CIC_W)
    ) u_ch_r (
        .clk     (clk),
        .reset   (reset),
        .bit_in  (adc_in_r),
        .tick    (tick),
        .comb_go (comb_go),
        .fb      (adc_fb_r),
        .sample  (sample_out_r),
        .clip    (clip_r)
    );

endmodule

// File: tb/tb_module_stereo_adc_input.sv
// ---------------------------------------------------------------------------
// tb_module_stereo_adc_input
//
// Directed bench for the stereo sigma-delta front end. The bench drives one
// modulator bit per tick, runs its own CIC reference on those bits and
// queues the expected sample and ready-pulse time for every frame; a
// monitor pops and compares whenever sample_out_rdy is seen.
// ---------------------------------------------------------------------------
module tb_module_stereo_adc_input;

    localparam int CLK_DIV = 32;
    localparam int DECIM   = 32;

    logic        clk;
    logic        reset;
    logic        adc_in_l;
    logic        adc_in_r;
    logic        adc_fb_l;
    logic        adc_fb_r;
    logic        sample_out_rdy;
    logic [17:0] sample_out_l;
    logic [17:0] sample_out_r;
    logic        clip_l;
    logic        clip_r;

    module_stereo_adc_input #(
        .CLK_DIV (CLK_DIV),
        .DECIM   (DECIM),
        .CIC_W   (18)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .adc_in_l       (adc_in_l),
        .adc_in_r       (adc_in_r),
        .adc_fb_l       (adc_fb_l),
        .adc_fb_r       (adc_fb_r),
        .sample_out_rdy (sample_out_rdy),
        .sample_out_l   (sample_out_l),
        .sample_out_r   (sample_out_r),
        .clip_l         (clip_l),
        .clip_r         (clip_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        int exp_edge;
        bit chk;
        int l;
        int r;
        int cl;
        int cr;
        bit has_const;
        int kl;
        int kr;
        int kcl;
        int kcr;
        int tol_l;
        int tol_r;
    } exp_t;

    exp_t sb[$];

    int passed = 0;
    int total  = 0;

    // Reference CIC state, one entry per channel (0 = left, 1 = right).
    logic [17:0] mi1[2];
    logic [17:0] mi2[2];
    logic [17:0] mi3[2];
    logic [17:0] md1[2];
    logic [17:0] md2[2];
    logic [17:0] md3[2];
    logic        prev_fb[2];
    int          m_dec;
    int          samples_since_reset;
    int          frames_in_pattern;
    int          pat_l;
    int          pat_r;
    bit          first_after_reset;
    int          rel_edge;
    logic        prev_rdy;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic checkNear(input string tag, input int obs, input int exp, input int tol);
        total++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) passed++;
        else $error("[TB] FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    endtask

    // Bit pattern generators: 0 all zeros, 1 all ones, 2 alternating 1/0,
    // 3 density 3/4 as 1110 repeating.
    function automatic logic pattern_bit(input int pat, input int idx);
        case (pat)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (idx % 2) == 0;
            default: return (idx % 4) != 3;
        endcase
    endfunction

    // Steady-state output each pattern must settle to.
    task automatic get_target(input int pat, output int val, output int clp, output int tol);
        case (pat)
            0:       begin val = -131072; clp = 0; tol = 0; end
            1:       begin val = 131071;  clp = 1; tol = 0; end
            2:       begin val = 0;       clp = 0; tol = 4; end
            default: begin val = 65536;   clp = 0; tol = 4; end
        endcase
    endtask

    task automatic ref_scale(input logic [17:0] c, output int val, output int clp);
        int y;
        y = int'($signed(c));
        if (y > 32767) begin
            val = 131071;
            clp = 1;
        end else if (y < -32768) begin
            val = -131072;
            clp = 1;
        end else begin
            val = y * 4;
            clp = 0;
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            mi1[ch] = '0; mi2[ch] = '0; mi3[ch] = '0;
            md1[ch] = '0; md2[ch] = '0; md3[ch] = '0;
            prev_fb[ch] = 1'b0;
        end
        m_dec               = 0;
        samples_since_reset = 0;
        frames_in_pattern   = 0;
    endtask

    // Advance the reference by one tick; on a frame end queue the expected
    // output. Called at the negedge right after the tick edge.
    task automatic model_tick(input logic bl, input logic br);
        logic [17:0] c1, c2, c3;
        int          val[2];
        int          clp[2];
        exp_t        e;
        for (int ch = 0; ch < 2; ch++) begin
            mi3[ch] = mi3[ch] + mi2[ch];
            mi2[ch] = mi2[ch] + mi1[ch];
            mi1[ch] = mi1[ch] + (((ch == 0) ? bl : br) ? 18'd1 : 18'h3FFFF);
        end
        if (m_dec == DECIM - 1) begin
            m_dec = 0;
            for (int ch = 0; ch < 2; ch++) begin
                c1 = mi3[ch] - md1[ch];
                c2 = c1 - md2[ch];
                c3 = c2 - md3[ch];
                md1[ch] = mi3[ch];
                md2[ch] = c1;
                md3[ch] = c2;
                ref_scale(c3, val[ch], clp[ch]);
            end
            frames_in_pattern++;
            e.exp_edge  = edge_cnt + 1;
            e.chk       = samples_since_reset >= 3;
            e.l         = val[0];
            e.r         = val[1];
            e.cl        = clp[0];
            e.cr        = clp[1];
            e.has_const = e.chk && (frames_in_pattern >= 3);
            get_target(pat_l, e.kl, e.kcl, e.tol_l);
            get_target(pat_r, e.kr, e.kcr, e.tol_r);
            samples_since_reset++;
            sb.push_back(e);
        end else begin
            m_dec++;
        end
    endtask

    // One modulator tick: entered at the negedge after the previous tick
    // edge (div_cnt == 0). An optional glitch flips the left input across
    // the edge just before the tick; it must not reach the consumed bit.
    task automatic applyStimulus(input logic bl, input logic br, input bit glitch);
        adc_in_l = bl;
        adc_in_r = br;
        for (int k = 1; k <= CLK_DIV; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 16) begin
                checkOutput("fb_hold_l", int'(adc_fb_l), int'(prev_fb[0]));
                checkOutput("fb_hold_r", int'(adc_fb_r), int'(prev_fb[1]));
            end
            if (glitch && k == CLK_DIV - 2) adc_in_l = ~bl;
            if (glitch && k == CLK_DIV - 1) adc_in_l = bl;
        end
        checkOutput("fb_tick_l", int'(adc_fb_l), int'(bl));
        checkOutput("fb_tick_r", int'(adc_fb_r), int'(br));
        prev_fb[0] = bl;
        prev_fb[1] = br;
        model_tick(bl, br);
    endtask

    task automatic run_frames(input int nframes, input int pl, input int pr, input bit glitch);
        pat_l             = pl;
        pat_r             = pr;
        frames_in_pattern = 0;
        for (int f = 0; f < nframes; f++) begin
            for (int t = 0; t < DECIM; t++) begin
                applyStimulus(pattern_bit(pl, f * DECIM + t), pattern_bit(pr, f * DECIM + t),
                              glitch && (t == DECIM - 1));
            end
        end
    endtask

    task automatic check_reset_outputs();
        checkOutput("rst_known", int'($isunknown({sample_out_rdy, sample_out_l, sample_out_r,
                                                  clip_l, clip_r, adc_fb_l, adc_fb_r})), 0);
        checkOutput("rst_rdy", int'(sample_out_rdy), 0);
        checkOutput("rst_sample_l", int'(sample_out_l), 0);
        checkOutput("rst_sample_r", int'(sample_out_r), 0);
        checkOutput("rst_clip_l", int'(clip_l), 0);
        checkOutput("rst_clip_r", int'(clip_r), 0);
        checkOutput("rst_fb_l", int'(adc_fb_l), 0);
        checkOutput("rst_fb_r", int'(adc_fb_r), 0);
    endtask

    // Scoreboard consumer: every observed ready pulse must match the next
    // queued frame in time and, after warm-up, in value.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_rdy = 1'b0;
        end else begin
            if (sample_out_rdy === 1'b1) begin
                checkOutput("rdy_width", int'(prev_rdy), 0);
                checkOutput("out_known", int'($isunknown({sample_out_l, sample_out_r,
                                                          clip_l, clip_r})), 0);
                checkOutput("rdy_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("rdy_time", edge_cnt, e.exp_edge);
                    if (first_after_reset) begin
                        checkOutput("rdy_after_reset", edge_cnt - rel_edge + 1, DECIM * CLK_DIV + 2);
                        first_after_reset = 1'b0;
                    end
                    if (e.chk) begin
                        checkOutput("ref_l", int'($signed(sample_out_l)), e.l);
                        checkOutput("ref_r", int'($signed(sample_out_r)), e.r);
                        checkOutput("ref_clip_l", int'(clip_l), e.cl);
                        checkOutput("ref_clip_r", int'(clip_r), e.cr);
                    end
                    if (e.has_const) begin
                        checkNear("dc_l", int'($signed(sample_out_l)), e.kl, e.tol_l);
                        checkNear("dc_r", int'($signed(sample_out_r)), e.kr, e.tol_r);
                        checkOutput("dc_clip_l", int'(clip_l), e.kcl);
                        checkOutput("dc_clip_r", int'(clip_r), e.kcr);
                    end
                end
            end
            prev_rdy = sample_out_rdy;
        end
    end

    initial begin
        reset             = 1'b1;
        adc_in_l          = 1'b0;
        adc_in_r          = 1'b0;
        first_after_reset = 1'b0;
        rel_edge          = 0;
        pat_l             = 0;
        pat_r             = 0;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs();

        reset             = 1'b0;
        rel_edge          = edge_cnt;
        first_after_reset = 1'b1;
        $display("[TB] reset released, all-zero input");
        run_frames(6, 0, 0, 1'b0);

        $display("[TB] all-ones input with glitches near frame-end ticks");
        run_frames(5, 1, 1, 1'b1);

        $display("[TB] alternating left, ones right");
        run_frames(5, 2, 1, 1'b0);

        $display("[TB] density 3/4 on both channels");
        run_frames(5, 3, 3, 1'b1);

        // Stop mid-frame (dec_cnt = 15) and pulse reset for 5 cycles.
        for (int t = 0; t < 15; t++) begin
            applyStimulus(pattern_bit(3, t), pattern_bit(3, t), 1'b0);
        end
        $display("[TB] mid-frame reset");
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs();
        end
        checkOutput("sb_empty_at_reset", sb.size(), 0);
        sb.delete();
        model_reset();
        reset             = 1'b0;
        rel_edge          = edge_cnt;
        first_after_reset = 1'b1;
        run_frames(5, 0, 3, 1'b0);

        repeat (4) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/module_stereo_adc_input.md
Name: module_stereo_adc_input

Overview:
Stereo sigma-delta ADC front end with decimation. It accepts two 1-bit modulator bitstreams sampled at 1536 kHz and drives the matching feedback bits back to the external RC/comparator loop. A 3rd-order CIC decimator (R=32) per channel produces 18-bit signed samples at 48 kHz. It sits at the audio input edge of the synth and feeds the 48 kHz sample domain, using the same sample_rdy pulse convention as the DAC output path.

Parameters:
CLK_DIV, 32, clk cycles per 1536 kHz modulator tick (clk = 49.152 MHz nominal)
DECIM, 32, modulator ticks per output sample; fixed at 32 (value relied upon by the scaling rule)
CIC_W, 18, CIC integrator/comb register width in bits; modular arithmetic

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
adc_in_l  in  1  left comparator output, asynchronous to clk
adc_in_r  in  1  right comparator output, asynchronous to clk
adc_fb_l  out  1  left feedback bit to RC integrator
adc_fb_r  out  1  right feedback bit to RC integrator
sample_out_rdy  out  1  one-cycle pulse: sample_out_l/r valid
sample_out_l  out  18  signed left sample, 48 kHz
sample_out_r  out  18  signed right sample, 48 kHz
clip_l  out  1  left saturated this sample; valid with sample_out_rdy
clip_r  out  1  right saturated this sample; valid with sample_out_rdy

Behaviour:
- Reset: all outputs 0; div_cnt, dec_cnt, synchronisers, integrators, comb delays all 0.
- Sync: 2-flop synchroniser per channel on adc_in_*. Bits are only consumed at ticks.
- Tick: div_cnt counts 0..CLK_DIV-1 and wraps. tick = (div_cnt==CLK_DIV-1). The first tick occurs CLK_DIV cycles after reset release.
- On tick, per channel:
  - b = synchronised bit.
  - adc_fb_* <= b.
  - x = +1 if b=1, else -1.
  - int1 += x; int2 += int1; int3 += int2 (old values, registered; all CIC_W-bit wrap).
- dec_cnt counts ticks 0..DECIM-1 and wraps.
- Frame end: a tick with dec_cnt==DECIM-1 sets comb_go for the next cycle (cycle T+1). In T+1 the three comb stages run combinationally on int3 (already updated at the edge ending T), each using its D=1 delay register:
  - c1 = int3 - d1; c2 = c1 - d2; c3 = c2 - d3.
  - d1 <= int3; d2 <= c1; d3 <= c2.
  - The result is registered.
- Output: at the edge ending T+1, sample_out_* and clip_* load, and sample_out_rdy = 1 during T+2 only. Latency is 2 clk cycles from the frame-end tick. Outputs hold between pulses.
- Scaling: y = c3 (range ±32768). out = y*4.
  - +32768 saturates to +131071 with clip=1.
  - Lower bound -131072 is exact, clip=0.
  - Otherwise clip=0.
- First 3 output samples after reset are CIC warm-up and are not checked for value. Pulses still occur.
- DC gain: a constant density p of ones gives a steady-state output of round((2p-1)*131072), saturated as above.
- Simultaneous events: tick and comb_go never coincide because CLK_DIV ≥ 3. A CLK_DIV < 3 is illegal; flag it with a simulation-time $display error.
- Reset mid-frame: immediate clear. The next sample_out_rdy occurs DECIM*CLK_DIV + 2 cycles after release (first tick after CLK_DIV cycles, frame end after 32 ticks).
- Left and right channels share all counters and strobes; their outputs are always simultaneous.

Decomposition:
- Shared package/include (alongside globals.vh): CIC_ORDER=3, DECIM_LOG2=5, SAMPLE_W=18, OUT_SHIFT=2, and the CLK_DIV_1536K constant (reuse the existing definition).
- Sub-module cic3_decim_ch, instantiated twice (l/r). Per channel it contains:
  - synchroniser, feedback register, integrators, combs, saturating scaler.
  - inputs: clk, reset, bit_in, tick, comb_go.
  - outputs: fb, sample, clip.
- Top level holds div_cnt, dec_cnt, comb_go and the sample_out_rdy register.

Test Plan:
- Reset, then hold both inputs 0 → after warm-up, every pulse gives sample_out_l/r = -131072 with clip=0. Pulse spacing is exactly 1024 clk cycles.
- Hold both inputs 1 → +131071 with clip_l=clip_r=1. adc_fb_* = 1, updated only on tick edges.
- Alternating 1/0 per tick on left, constant 1 on right → left settles to 0 (±4), right to 131071. Demonstrates channel independence.
- Density 3/4 (pattern 1110 repeating) → output settles to 65536 (±4). Compare against a bit-exact reference CIC model for all samples after warm-up.
- Assert reset for 5 cycles mid-frame (dec_cnt ≈ 15) → all outputs read 0 during reset. The first pulse arrives exactly 32*CLK_DIV+2 cycles after release.
- Check pulse timing: sample_out_rdy is high for exactly 1 cycle, and 2 cycles after the tick where dec_cnt==31. Verify over 100 samples, including a single-bit toggle of adc_in near a tick edge (synchroniser metastability path, no X propagation).
